// File: rtl/countdown_mmss.sv
// countdown_mmss -- four-digit BCD MM:SS countdown (99:59 .. 00:00) for
// irrigation watering durations. Decrements once per 1 Hz tick while in RUN,
// pulses done on reaching 00:00, and flags rejected presets.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   load        load preset_min/preset_sec (IDLE, PAUSED, EXPIRED only)
//   preset_min  BCD minutes preset {tens, units}
//   preset_sec  BCD seconds preset {tens, units}
//   start       start/resume request (level sampled)
//   stop        pause request (level sampled)
//   tick        one-clock-wide 1 Hz enable
//   min_bcd     current minutes, BCD
//   sec_bcd     current seconds, BCD
//   running     high while in RUN
//   done        one-cycle pulse on reaching 00:00 from RUN
//   preset_err  one-cycle pulse when a load was rejected

// One BCD digit of the borrow chain: decrements when borrow_in is set,
// wrapping to `wrap` at zero and passing the borrow on to the next digit.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic [3:0] wrap,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);
    assign borrow_out = borrow_in && (digit == 4'd0);
    assign next_digit = !borrow_in       ? digit :
                        (digit == 4'd0)  ? wrap  : digit - 4'd1;
endmodule

module countdown_mmss (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       preset_err
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam int NUM_DIG = 4;
    // Digit order: [0] sec units, [1] sec tens, [2] min units, [3] min tens.
    // Minutes tens wraps to 0, i.e. it stops there.
    localparam logic [NUM_DIG-1:0][3:0] WRAP = {4'd0, 4'd9, 4'd5, 4'd9};

    state_t                    state;
    logic [NUM_DIG-1:0][3:0]   digits;
    logic [NUM_DIG-1:0][3:0]   dec_digits;
    logic [NUM_DIG:0]          borrow;
    logic                      dec_zero;
    logic                      cnt_zero;
    logic                      preset_ok;

    assign borrow[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_dig
            bcd_digit_dec u_dig (
                .digit      (digits[g]),
                .wrap       (WRAP[g]),
                .borrow_in  (borrow[g]),
                .next_digit (dec_digits[g]),
                .borrow_out (borrow[g+1])
            );
        end
    endgenerate

    assign dec_zero = (dec_digits == '0);
    assign cnt_zero = (digits == '0);

    // Every nibble a decimal digit, and seconds tens at most 5.
    assign preset_ok = (preset_min[7:4] <= 4'd9) && (preset_min[3:0] <= 4'd9) &&
                       (preset_sec[7:4] <= 4'd5) && (preset_sec[3:0] <= 4'd9);

    assign min_bcd = digits[3:2];
    assign sec_bcd = digits[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            digits     <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            preset_err <= 1'b0;
        end else begin
            done       <= 1'b0;
            preset_err <= 1'b0;
            case (state)
                RUN: begin
                    // load and start have no effect while counting.
                    if (stop) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (tick && !borrow[NUM_DIG]) begin
                        // borrow out of the top digit means 00:00; never
                        // decrement past it.
                        digits <= dec_digits;
                        if (dec_zero) begin
                            state   <= EXPIRED;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    // stop outranks everything below it even where it has
                    // no effect of its own.
                    if (stop) begin
                        state <= state;
                    end else if (load) begin
                        if (preset_ok) begin
                            digits <= {preset_min, preset_sec};
                            if (state == EXPIRED) state <= IDLE;
                        end else begin
                            preset_err <= 1'b1;
                        end
                    end else if (start && state != EXPIRED && !cnt_zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
